// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Data side wins ties, bounded by a starvation counter that eventually forces an instruction grant.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [`ADDR_SIZE:0]  i_addr,
    input  logic                 i_enable,
    output logic [`INSTR_SIZE:0] i_data,
    output logic                 i_ready,
    input  logic [`ADDR_SIZE:0]  d_addr,
    input  logic                 d_r_enable,
    input  logic                 d_w_enable,
    input  logic [`INSTR_SIZE:0] d_w_data,
    output logic [`INSTR_SIZE:0] d_r_data,
    output logic                 d_ready,
    output logic [`ADDR_SIZE:0]  m_addr,
    output logic                 m_r_enable,
    output logic                 m_w_enable,
    output logic [`INSTR_SIZE:0] m_w_data,
    input  logic [`INSTR_SIZE:0] m_r_data,
    input  logic                 m_ready,
    output logic                 busy
);

    localparam int unsigned CNT_W     = 3;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_req;
    logic             i_win;

    assign d_req = d_r_enable | d_w_enable;
    // Instruction wins when alone, or when data has already been favoured LIMIT times in a row.
    assign i_win = i_enable & (~d_req | (starve_cnt == LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_addr     <= '0;
            m_w_data   <= '0;
            m_r_enable <= 1'b0;
            m_w_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_win) begin
                        state      <= GRANT_I;
                        starve_cnt <= '0;
                        m_addr     <= i_addr;
                        m_r_enable <= 1'b1;
                        m_w_enable <= 1'b0;
                    end else if (d_req) begin
                        state      <= GRANT_D;
                        m_addr     <= d_addr;
                        m_w_data   <= d_w_data;
                        m_r_enable <= ~d_w_enable;
                        m_w_enable <= d_w_enable;
                        if (!i_enable) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != LIMIT) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else if (!i_enable) begin
                        starve_cnt <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // Request inputs are deliberately ignored here; only memory completion ends a grant.
                    if (m_ready) begin
                        state      <= IDLE;
                        m_r_enable <= 1'b0;
                        m_w_enable <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_ready  = (state == GRANT_I) & m_ready;
    assign d_ready  = (state == GRANT_D) & m_ready;
    assign i_data   = m_r_data;
    assign d_r_data = m_r_data;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model of ownership and starvation
// plus a scripted memory responder, checked every cycle and pinned by literal expectations.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

module tb_mem_arbiter;

    localparam int unsigned AW    = `ADDR_SIZE + 1;
    localparam int unsigned DW    = `INSTR_SIZE + 1;
    localparam int          LIMIT = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] i_addr;
    logic          i_enable;
    logic [DW-1:0] i_data;
    logic          i_ready;
    logic [AW-1:0] d_addr;
    logic          d_r_enable;
    logic          d_w_enable;
    logic [DW-1:0] d_w_data;
    logic [DW-1:0] d_r_data;
    logic          d_ready;
    logic [AW-1:0] m_addr;
    logic          m_r_enable;
    logic          m_w_enable;
    logic [DW-1:0] m_w_data;
    logic [DW-1:0] m_r_data;
    logic          m_ready;
    logic          busy;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_enable(i_enable), .i_data(i_data), .i_ready(i_ready),
        .d_addr(d_addr), .d_r_enable(d_r_enable), .d_w_enable(d_w_enable),
        .d_w_data(d_w_data), .d_r_data(d_r_data), .d_ready(d_ready),
        .m_addr(m_addr), .m_r_enable(m_r_enable), .m_w_enable(m_w_enable),
        .m_w_data(m_w_data), .m_r_data(m_r_data), .m_ready(m_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who owns the memory (0 none, 1 instr, 2 data) and what the memory was handed.
    int            own = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic          e_re = 1'b0;
    logic          e_we = 1'b0;
    int            streak = 0;
    int            wait_cnt = 0;
    bit            model_valid = 1'b0;
    string         glog = "";

    // Stimulus knobs: outstanding transactions per requester and memory behaviour.
    int            i_left = 0;
    int            d_left = 0;
    bit            d_rd = 1'b0;
    bit            d_wr = 1'b0;
    int            mem_lat = 0;
    bit            idle_noise = 1'b0;
    logic [DW-1:0] mem_data = '0;

    logic          s_busy, s_ir, s_dr, s_re, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_idata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic mr;
        bit   e_ir, e_dr, ireq, dreq;
        @(negedge clk);
        i_enable   = (i_left > 0);
        d_r_enable = (d_left > 0) && d_rd;
        d_w_enable = (d_left > 0) && d_wr;
        mr         = (own != 0) ? (wait_cnt >= mem_lat) : idle_noise;
        m_ready    = mr;
        m_r_data   = mem_data;
        #1;
        e_ir    = (own == 1) && mr;
        e_dr    = (own == 2) && mr;
        s_busy  = busy;
        s_ir    = i_ready;
        s_dr    = d_ready;
        s_re    = m_r_enable;
        s_we    = m_w_enable;
        s_addr  = m_addr;
        s_wdata = m_w_data;
        s_idata = i_data;
        if (model_valid) begin
            chk("busy", busy, own != 0);
            chk("i_ready", i_ready, e_ir);
            chk("d_ready", d_ready, e_dr);
            chk("m_r_enable", m_r_enable, e_re);
            chk("m_w_enable", m_w_enable, e_we);
            chk("m_addr", m_addr, e_addr);
            chk("m_w_data", m_w_data, e_wdata);
            chk("i_data", i_data, mem_data);
            chk("d_r_data", d_r_data, mem_data);
        end
        @(posedge clk);
        ireq = i_enable;
        dreq = d_r_enable | d_w_enable;
        if (reset) begin
            own = 0; e_addr = '0; e_wdata = '0; e_re = 1'b0; e_we = 1'b0;
            streak = 0; model_valid = 1'b1;
        end else if (own == 0) begin
            wait_cnt = 0;
            if (ireq && (!dreq || streak >= LIMIT)) begin
                own = 1; e_addr = i_addr; e_re = 1'b1; e_we = 1'b0; streak = 0;
                glog = {glog, "I"};
            end else if (dreq) begin
                own = 2; e_addr = d_addr; e_wdata = d_w_data;
                e_we = d_w_enable; e_re = !d_w_enable;
                streak = ireq ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
                glog = {glog, "D"};
            end else if (!ireq) begin
                streak = 0;
            end
        end else if (mr) begin
            own = 0; e_re = 1'b0; e_we = 1'b0;
        end else begin
            wait_cnt++;
        end
        if (e_ir && i_left > 0) i_left--;
        if (e_dr && d_left > 0) d_left--;
        #1;
    endtask

    initial begin
        int pulses;
        int busy_cycles;
        int both;
        reset = 1'b1; i_addr = '0; i_enable = 1'b0; d_addr = '0;
        d_r_enable = 1'b0; d_w_enable = 1'b0; d_w_data = '0;
        m_r_data = '0; m_ready = 1'b0;

        cycle();
        cycle();
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_m_r_enable", s_re, 1'b0);
        chk("rst_m_addr", s_addr, '0);
        reset = 1'b0;
        cycle();

        // Instruction fetch, memory answers one cycle after the strobe.
        i_addr = AW'(32'h10); mem_data = DW'(32'h00A00093); mem_lat = 1; i_left = 1;
        cycle();
        chk("if_n_busy", s_busy, 1'b0);
        cycle();
        chk("if_n1_m_r_enable", s_re, 1'b1);
        chk("if_n1_m_addr", s_addr, 64'h10);
        chk("if_n1_i_ready", s_ir, 1'b0);
        cycle();
        chk("if_n2_i_ready", s_ir, 1'b1);
        chk("if_n2_i_data", s_idata, 64'h00A00093);
        cycle();
        chk("if_n3_busy", s_busy, 1'b0);

        // Data write with immediate memory response.
        d_addr = AW'(32'h40); d_w_data = DW'(32'hDEADBEEF); d_wr = 1'b1; d_rd = 1'b0;
        mem_lat = 0; d_left = 1; pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            pulses += int'(s_dr);
            chk("wr_i_ready", s_ir, 1'b0);
            if (k == 1) begin
                chk("wr_m_w_enable", s_we, 1'b1);
                chk("wr_m_r_enable", s_re, 1'b0);
                chk("wr_m_addr", s_addr, 64'h40);
                chk("wr_m_w_data", s_wdata, 64'hDEADBEEF);
            end
        end
        chk("wr_d_ready_pulses", pulses, 1);

        // Both sides held high: starvation limit forces every fifth grant to instruction.
        glog = ""; d_wr = 1'b0; d_rd = 1'b1; i_left = 2; d_left = 8;
        idle_noise = 1'b1; both = 0;
        for (int k = 0; k < 200 && (i_left > 0 || d_left > 0); k++) begin
            mem_data = DW'($urandom());
            cycle();
            both += int'(s_ir & s_dr);
        end
        chk("cont_done", i_left + d_left, 0);
        chk("cont_overlap", both, 0);
        checks++;
        if (glog != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL cont_order: got %s expected DDDDIDDDDI", glog);
        end
        idle_noise = 1'b0;
        cycle();

        // Memory stall for five cycles; address input wanders and the request drops mid-grant.
        d_addr = AW'(32'h80); d_left = 1; mem_lat = 5; busy_cycles = 0; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            busy_cycles += int'(s_busy);
            pulses += int'(s_dr);
            if (k == 3) chk("stall_m_addr", s_addr, 64'h80);
            if (k == 2) d_left = 0;
            d_addr = AW'($urandom());
            mem_data = DW'($urandom());
        end
        chk("stall_busy_cycles", busy_cycles, 6);
        chk("stall_d_ready_pulses", pulses, 1);

        // Reset abandons a data grant; pending fetch is granted afterwards.
        d_addr = AW'(32'h90); d_left = 1; mem_lat = 20; i_addr = AW'(32'h24);
        cycle();
        cycle();
        cycle();
        chk("rg_busy_before", s_busy, 1'b1);
        reset = 1'b1; d_left = 0; i_left = 1;
        cycle();
        reset = 1'b0; mem_lat = 2;
        cycle();
        chk("rg_busy", s_busy, 1'b0);
        chk("rg_m_r_enable", s_re, 1'b0);
        chk("rg_d_ready", s_dr, 1'b0);
        chk("rg_m_addr", s_addr, 64'h0);
        cycle();
        chk("rg_i_grant_re", s_re, 1'b1);
        chk("rg_i_grant_addr", s_addr, 64'h24);
        for (int k = 0; k < 20 && i_left > 0; k++) cycle();
        chk("rg_i_done", i_left, 0);

        // Read and write together are a write.
        d_rd = 1'b1; d_wr = 1'b1; d_addr = AW'(32'h44); d_w_data = DW'(32'h12345678);
        mem_lat = 0; d_left = 1;
        cycle();
        cycle();
        chk("rw_m_w_enable", s_we, 1'b1);
        chk("rw_m_r_enable", s_re, 1'b0);
        chk("rw_m_w_data", s_wdata, 64'h12345678);
        for (int k = 0; k < 3; k++) cycle();
        chk("rw_done", d_left, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
